gate_op_arbiter: RTL and testbench

GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

---
 rtl/gate_op_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/gate_op_arbiter.sv | 174 +++++++++++++++++
 tb/tb_gate_op_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_op_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_op_pkg
// Description : Shared types for the gate-op arbiter: op-code enum, FSM
//               state enum and the grant-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_op_pkg;

    // Bitwise operation selected by each requester
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    // Controller states: accept a request, evaluate it, hold the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of each per-requester grant statistics counter
    localparam int c_cnt_width = 16;

endpackage : gate_op_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Grants the first valid
//               requester at or after ptr in circular order (one-hot or zero).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W:0]   w_pos;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters starting at ptr, wrapping, and keep the first valid
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_pos >= (PTR_W+1)'(NUM_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(NUM_REQ);
            end
            w_idx = w_pos[PTR_W-1:0];
            if (!w_found && valid[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gate_op_arbiter
// Description : Round-robin arbiter in front of a shared bitwise gate unit
//               (AND/OR/XOR/NAND). One request in flight; IDLE -> EXEC -> RESP.
//               Optional macro GATE_OP_ARBITER_STATS_EN adds grant_cnt, a set
//               of per-requester 16-bit saturating handshake counters.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ-1:0]                    req_valid,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]              req_a,
    input  logic [NUM_REQ*WIDTH-1:0]              req_b,
    input  logic [NUM_REQ*2-1:0]                  req_op,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [WIDTH-1:0]                      rsp_data
`ifdef GATE_OP_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*c_cnt_width-1:0]        grant_cnt
`endif
);

    localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              r_state;
    state_e              w_next_state;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    op_e                 r_op;
    logic [c_id_w-1:0]   r_id;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_hs;
    logic [c_id_w-1:0]   w_grant_idx;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;
    op_e                 w_sel_op;
    logic [WIDTH-1:0]    w_result;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_id_w)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant)
    );

    assign w_hs = |(req_valid & req_ready);

    // Decode the one-hot grant into an index and mux out that requester's operands
    always_comb begin
        w_grant_idx = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_op    = OP_AND;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_id_w'(i);
                w_sel_a     = req_a[i*WIDTH +: WIDTH];
                w_sel_b     = req_b[i*WIDTH +: WIDTH];
                w_sel_op    = op_e'(req_op[i*2 +: 2]);
            end
        end
    end

    // Shared gate unit working on the captured operands
    always_comb begin
        w_result = '0;
        case (r_op)
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_NAND: w_result = ~(r_a & r_b);
            default: w_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: grants only in IDLE and never while reset is held
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        if (r_state == IDLE && !rst) begin
            req_ready = w_grant;
        end
        if (r_state == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // Capture the granted request and advance the round-robin pointer past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_AND;
            r_id     <= '0;
        end else if (r_state == IDLE && w_hs) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
            r_id <= w_grant_idx;
            if (w_grant_idx == c_id_w'(NUM_REQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_grant_idx + c_id_w'(1);
            end
        end
    end

    // Register the result once in EXEC so it stays stable through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (r_state == EXEC) begin
            rsp_data <= w_result;
            rsp_id   <= r_id;
        end
    end

`ifdef GATE_OP_ARBITER_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [c_cnt_width-1:0] r_cnt;

        // Saturating handshake counter for this requester
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (req_valid[gi] && req_ready[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + c_cnt_width'(1);
            end
        end

        assign grant_cnt[gi*c_cnt_width +: c_cnt_width] = r_cnt;
    end
`else
    // Statistics counters not built
`endif

endmodule : gate_op_arbiter
`default_nettype wire

// File: tb/tb_gate_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_op_arbiter
// Description : Self-checking bench for gate_op_arbiter: directed vector
//               table, round-robin order, backpressure, mid-flight reset and
//               a randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*2-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
`ifdef GATE_OP_ARBITER_STATS_EN
    logic [N*16-1:0]  grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gate_op_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef GATE_OP_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gate_ref(input logic [7:0] a, input logic [7:0] b, input int op);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // First valid requester at or after p, circularly; -1 if none
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic load_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a = $urandom();
        req_b = $urandom();
        req_op = 8'($urandom());
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_op[idx*2 +: 2] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Single isolated request with rsp_ready high; checks timing and result
    task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op, input logic [7:0] exp);
        @(negedge clk);
        load_req(idx, a, b, op);
        req_valid = onehot(idx);
        rsp_ready = 1'b1;
        #1 chk("vec_req_ready", 32'(req_ready), 32'(onehot(idx)));
        @(negedge clk);
        req_valid = '0;
        #1 chk("vec_exec_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_id", 32'(rsp_id), 32'(idx));
        chk("vec_rsp_data", 32'(rsp_data), 32'(exp));
        @(negedge clk);
        #1 chk("vec_back_idle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int got[5];
        int ngot;
        int exp_order[5];
        int m_ptr;
        bit m_busy;
        int m_age;
        int m_id;
        logic [7:0] m_data;

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending to prove req_ready is held off
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        vecs[0] = '{idx: 2, a: 8'hF0, b: 8'h3C, op: 2'd0, exp: 8'h30};
        vecs[1] = '{idx: 1, a: 8'hAA, b: 8'h0F, op: 2'd1, exp: 8'hAF};
        vecs[2] = '{idx: 3, a: 8'hAA, b: 8'h0F, op: 2'd2, exp: 8'hA5};
        vecs[3] = '{idx: 0, a: 8'hAA, b: 8'h0F, op: 2'd3, exp: 8'hF5};
        vecs[4] = '{idx: 0, a: 8'h00, b: 8'h00, op: 2'd3, exp: 8'hFF};
        vecs[5] = '{idx: 3, a: 8'hFF, b: 8'hFF, op: 2'd2, exp: 8'h00};
        for (int v = 0; v < 6; v++) begin
            single(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].exp);
        end

        // Round-robin order with all requesters held valid
        do_reset();
        @(negedge clk);
        load_req(0, 8'h11, 8'h22, 2'd1);
        req_valid = '1;
        rsp_ready = 1'b1;
        ngot = 0;
        exp_order = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 40 && ngot < 5; c++) begin
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && ngot < 5) begin
                    got[ngot] = i;
                    ngot++;
                end
            end
            if (ngot < 5) @(negedge clk);
        end
        req_valid = '0;
        chk("rr_grant_count", 32'(ngot), 32'd5);
        for (int k = 0; k < 5 && k < ngot; k++) begin
            chk("rr_grant_order", 32'(got[k]), 32'(exp_order[k]));
        end
        repeat (4) @(negedge clk);

        // Backpressure: hold RESP for 10 cycles with other requesters waiting
        do_reset();
        @(negedge clk);
        load_req(3, 8'h5A, 8'hC3, 2'd2);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '1;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h99);
            chk("bp_rsp_id", 32'(rsp_id), 32'd3);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_idle_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // Reset while in EXEC aborts the result and clears the pointer
        repeat (2) @(negedge clk);
        load_req(2, 8'h0F, 8'hF0, 2'd1);
        req_valid = 4'b0100;
        #1 chk("rst_pre_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1 chk("rst_no_response", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        req_valid = 4'b1010;
        #1 chk("rst_ptr_cleared_grant", 32'(req_ready), 32'b0010);
        req_valid = '0;

        // Randomized traffic against a transaction-level model
        do_reset();
        m_ptr = 0;
        m_busy = 1'b0;
        m_age = 0;
        m_id = 0;
        m_data = '0;
        for (int c = 0; c < 1500; c++) begin
            int g;
            @(negedge clk);
            req_valid = N'($urandom());
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            req_a = $urandom();
            req_b = $urandom();
            req_op = 8'($urandom());
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            g = m_busy ? -1 : pick(req_valid, m_ptr);
            chk("rand_req_ready", 32'(req_ready), 32'(onehot(g)));
            chk("rand_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                chk("rand_rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rand_rsp_data", 32'(rsp_data), 32'(m_data));
            end
            // Advance the model across the coming clock edge
            if (!m_busy && g >= 0) begin
                m_busy = 1'b1;
                m_age = 1;
                m_id = g;
                m_data = gate_ref(req_a[g*W +: W], req_b[g*W +: W], int'(req_op[g*2 +: 2]));
                m_ptr = (g + 1) % N;
            end else if (m_busy && m_age == 1) begin
                m_age = 2;
            end else if (m_busy && m_age >= 2 && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
        req_valid = '0;

`ifdef GATE_OP_ARBITER_STATS_EN
        // Saturation of requester 1's counter; others stay at zero
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        begin
            int grants;
            grants = 0;
            for (int c = 0; c < 230000 && grants < 70000; c++) begin
                #1;
                if (req_ready[1]) grants++;
                @(negedge clk);
            end
            req_valid = '0;
            chk("stats_grants_issued", 32'(grants), 32'd70000);
        end
        repeat (4) @(negedge clk);
        chk("stats_cnt1_saturated", 32'(grant_cnt[16 +: 16]), 32'hFFFF);
        chk("stats_cnt0", 32'(grant_cnt[0 +: 16]), 32'd0);
        chk("stats_cnt2", 32'(grant_cnt[32 +: 16]), 32'd0);
        chk("stats_cnt3", 32'(grant_cnt[48 +: 16]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gate_op_arbiter
`default_nettype wire
